// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_stage_pkg;

  typedef enum logic {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  localparam logic [31:0]  NOP_INST         = 32'h0000_0013;
  localparam logic [31:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned  DEFAULT_DEPTH    = 2;

  // One buffered fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with flush; storage resets to INIT so the head is defined out of reset.
module if_fifo #(
  parameter int unsigned       DEPTH = 2,
  parameter int unsigned       WIDTH = 64,
  parameter logic [WIDTH-1:0]  INIT  = '0,
  localparam int unsigned      AW    = $clog2(DEPTH),
  localparam int unsigned      CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      mem_q   <= '{default: INIT};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push) mem_q[wptr_q] <= wdata_i;
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(push_i && !flush_i && full_o && !pop_i));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues in-order memory requests, buffers responses, drops stale ones after redirects.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [31:0]   redirect_tgt;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] occupancy;
  logic          req_accept;
  logic          fifo_push, fifo_pop, fifo_empty;
  logic          unused_fifo_full;
  logic          unused_redirect_lsb;
  fetch_entry_t  push_entry, head_entry;

  assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign occupancy           = OW'(fifo_count) + OW'(inflight_q);

  // Responses are kept only when nothing older is pending discard and no redirect is flushing this cycle.
  assign fifo_push  = imem_rsp_valid && !redirect_valid && (drop_q == '0);
  assign fifo_pop   = id_valid && id_ready && !redirect_valid;
  assign push_entry = '{pc: rsp_pc_q, inst: imem_rsp_data};

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    rsp_pc_d       = rsp_pc_q;
    drop_d         = drop_q;
    imem_req_valid = 1'b0;

    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   imem_req_valid = !redirect_valid && (occupancy < OW'(DEPTH));
      default: state_d = BOOT;
    endcase

    req_accept = imem_req_valid && imem_req_ready;
    inflight_d = inflight_q + CW'(req_accept) - CW'(imem_rsp_valid);

    if (req_accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (fifo_push)  rsp_pc_d   = rsp_pc_q + 32'd4;
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);

    // Everything still in flight belongs to the abandoned path.
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      drop_d     = inflight_q - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t)),
    .INIT  ({RESET_PC, NOP_INST})
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign imem_req_addr = fetch_pc_q;
  assign id_valid      = !fifo_empty;
  assign id_inst       = head_entry.inst;
  assign id_pc         = head_entry.pc;

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage with an in-order variable-latency memory model.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, id_valid, id_ready;
  logic [31:0] redirect_pc, id_inst, id_pc;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;

  exp_t        sb[$];    // fetched on the current path, not yet delivered to decode
  pend_t       memq[$];  // accepted by memory, response not yet returned
  int          arrived, since_rst, cyc, last_due, lat_min, lat_max;
  int          n_tests, n_fail, n_handshakes, stale_n;
  bit          cur_stale, exp_rv;
  logic [31:0] exp_req;

  if_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: returns responses in order, one per cycle at most, never stalled.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    cur_stale      = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      imem_rsp_valid = 1'b0;
      cur_stale      = 1'b0;
      if (!reset && memq.size() > 0 && memq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(memq[0].addr);
        cur_stale      = memq[0].stale;
        void'(memq.pop_front());
      end
    end
  end

  // Monitor: checks this cycle's outputs against the model, then applies this cycle's events.
  always @(negedge clk) begin
    if (reset) begin
      since_rst = 0;
    end else begin
      stale_n = (imem_rsp_valid && cur_stale) ? 1 : 0;
      foreach (memq[i]) if (memq[i].stale) stale_n++;
      exp_rv = (since_rst != 0) && !redirect_valid && ((sb.size() + stale_n) < DEPTH);
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_req);
      check("id_valid", 32'(id_valid), 32'(arrived > 0));
      if (id_valid && arrived > 0) begin
        check("id_pc", id_pc, sb[0].pc);
        check("id_inst", id_inst, sb[0].inst);
      end

      if (redirect_valid) begin
        sb.delete();
        arrived = 0;
        foreach (memq[i]) memq[i].stale = 1'b1;
        exp_req = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (id_valid && id_ready && arrived > 0) begin
          void'(sb.pop_front());
          arrived--;
          n_handshakes++;
        end
        if (imem_rsp_valid && !cur_stale) arrived++;
        if (imem_req_valid && imem_req_ready) begin
          pend_t p;
          int    due;
          sb.push_back('{pc: exp_req, inst: mem_word(exp_req)});
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          p.addr = imem_req_addr; p.due = due; p.stale = 1'b0;
          memq.push_back(p);
          exp_req = exp_req + 32'd4;
        end
      end
      since_rst++;
    end
  end

  task automatic drive(input bit rdy, input bit idr, input bit rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3, 0))
      0:       return $urandom & 32'h0000_0FFF;
      1:       return 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
      2:       return $urandom;
      default: return 32'h0000_0203;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_id_valid"},  32'(id_valid), 32'd0);
    check({tag, "_id_inst"},   id_inst, NOP_INST);
    check({tag, "_id_pc"},     id_pc, RST_PC);
    check({tag, "_req_addr"},  imem_req_addr, RST_PC);
  endtask

  task automatic clear_model();
    memq.delete();
    sb.delete();
    arrived  = 0;
    last_due = 0;
    exp_req  = RST_PC;
  endtask

  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    n_tests = 0; n_fail = 0; n_handshakes = 0; cyc = 0; since_rst = 0;
    lat_min = 1; lat_max = 1;
    clear_model();

    #13;
    check_reset_outputs("reset");
    @(posedge clk); #1; reset = 1'b0;

    // Straight-line fetch from RESET_PC with single-cycle memory.
    repeat (30) drive(1, 1, 0, '0);

    // Decode stalls: buffer fills and requests stop, head holds.
    repeat (12) drive(1, 0, 0, '0);
    #1;
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_id_valid", 32'(id_valid), 32'd1);
    repeat (10) drive(1, 1, 0, '0);

    // Redirects with requests in flight, unaligned target, and address wrap.
    lat_min = 3; lat_max = 3;
    repeat (6) drive(1, 1, 0, '0);
    drive(1, 1, 1, 32'h0000_0100);
    repeat (15) drive(1, 1, 0, '0);
    drive(1, 1, 1, 32'h0000_0203);
    repeat (10) drive(1, 1, 0, '0);
    lat_min = 1; lat_max = 1;
    drive(1, 1, 1, 32'hFFFF_FFF8);
    repeat (12) drive(1, 1, 0, '0);

    // Memory refuses requests for a few cycles.
    repeat (3) drive(0, 1, 0, '0);
    repeat (6) drive(1, 1, 0, '0);

    // Random traffic.
    lat_min = 1; lat_max = 4;
    repeat (3000) begin
      drive(int'($urandom_range(99, 0)) < 70, int'($urandom_range(99, 0)) < 60,
            int'($urandom_range(99, 0)) < 4, pick_target());
    end

    // Reset in the middle of traffic.
    lat_min = 3; lat_max = 3;
    repeat (8) drive(1, 1, 0, '0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    clear_model();
    imem_req_ready = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    lat_min = 1; lat_max = 2;
    repeat (40) drive(1, 1, 0, '0);

    check("progress", 32'(n_handshakes > 200), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
